// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, classifies each
// four-column frame and debounces presses and releases with a small FSM.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int unsigned DivW    = $clog2(SCAN_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [3:0]  DebN    = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StReleasing} state_e;

  logic [3:0]      rows_s1_q, rows_s2_q;
  logic [DivW-1:0] div_q;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [3:0]      cols_q;
  logic            tc, frame_end;

  // Frame accumulator: saturating hit count (0, 1, 2+) and the code of the first hit.
  logic [1:0]      hits_q, hits_d;
  logic [3:0]      acc_code_q, code_now;
  logic [2:0]      col_hits, hits_sum;
  logic [1:0]      col_row;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d, cnt_inc;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_pressed_q, key_pressed_d;
  logic            is_none, is_single;

  assign tc        = (div_q == DivLast);
  assign frame_end = tc && (col_idx_q == 2'd3);
  assign col_idx_d = tc ? col_idx_q + 2'd1 : col_idx_q;

  always_comb begin
    col_hits = 3'd0;
    col_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!rows_s2_q[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
    hits_sum = {1'b0, hits_q} + col_hits;
    hits_d   = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    code_now = (hits_q == 2'd0) ? {col_row, col_idx_q} : acc_code_q;
  end

  assign is_none   = (hits_d == 2'd0);
  assign is_single = (hits_d == 2'd1);
  assign cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_s1_q  <= 4'hF;
      rows_s2_q  <= 4'hF;
      div_q      <= '0;
      col_idx_q  <= 2'd0;
      cols_q     <= 4'b1110;
      hits_q     <= 2'd0;
      acc_code_q <= 4'd0;
    end else begin
      rows_s1_q <= rows;
      rows_s2_q <= rows_s1_q;
      div_q     <= tc ? '0 : div_q + 1'b1;
      col_idx_q <= col_idx_d;
      // Registered from the next column index so cols always matches col_idx.
      cols_q    <= ~(4'b0001 << col_idx_d);
      if (tc) begin
        hits_q     <= frame_end ? 2'd0 : hits_d;
        acc_code_q <= code_now;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cand_d        = cand_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_pressed_d = key_pressed_q;
    if (frame_end) begin
      unique case (state_q)
        StIdle: begin
          if (is_single) begin
            if (DebN <= 4'd1) begin
              state_d       = StPressed;
              key_code_d    = code_now;
              key_valid_d   = 1'b1;
              key_pressed_d = 1'b1;
              cnt_d         = 4'd0;
            end else begin
              state_d = StDebounce;
              cand_d  = code_now;
              cnt_d   = 4'd1;
            end
          end
        end
        StDebounce: begin
          if (is_single && code_now == cand_q) begin
            if (cnt_inc >= DebN) begin
              state_d       = StPressed;
              key_code_d    = cand_q;
              key_valid_d   = 1'b1;
              key_pressed_d = 1'b1;
              cnt_d         = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (is_single) begin
            cand_d = code_now;
            cnt_d  = 4'd1;
          end else begin
            state_d = StIdle;
            cnt_d   = 4'd0;
          end
        end
        StPressed: begin
          if (is_none) begin
            if (DebN <= 4'd1) begin
              state_d       = StIdle;
              key_pressed_d = 1'b0;
              cnt_d         = 4'd0;
            end else begin
              state_d = StReleasing;
              cnt_d   = 4'd1;
            end
          end
        end
        StReleasing: begin
          if (is_none) begin
            if (cnt_inc >= DebN) begin
              state_d       = StIdle;
              key_pressed_d = 1'b0;
              cnt_d         = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StPressed;
            cnt_d   = 4'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      cand_q        <= 4'd0;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cand_q        <= cand_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
    end
  end

  assign cols        = cols_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle frames);
// a behavioural keypad closes row/column contacts for the keys held in 'held'.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pressed;
  logic [15:0] held;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int v_n, v_cyc;
  logic [3:0] v_code;

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rows       (rows),
    .cols       (cols),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_pressed(key_pressed)
  );

  always #5 clk = ~clk;

  // Cycle count since reset release; frame ends fall on multiples of 16.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Key index = {row, col}: a held key pulls its row low while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (held[r*4+c] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) begin
      tick();
      if (key_valid === 1'b1) begin
        v_n++;
        v_cyc  = cyc;
        v_code = key_code;
      end
    end
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] exp_cols;
    int         bad_v, bad_p;
    one   = 4'b0001;
    reset = 1'b1;
    held  = 16'h0;
    repeat (3) tick();
    check("rst_cols", 32'(cols), 32'hE);
    check("rst_valid", 32'(key_valid), 0);
    check("rst_pressed", 32'(key_pressed), 0);
    check("rst_code", 32'(key_code), 0);
    reset = 1'b0;

    // Idle scanning: columns step every 4 cycles, no outputs.
    bad_v = 0;
    bad_p = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_cols = ~(one << ((k / 4) % 4));
      check($sformatf("scan_cols_%0d", k), 32'(cols), 32'(exp_cols));
      if (key_valid !== 1'b0) bad_v++;
      if (key_pressed !== 1'b0) bad_p++;
    end
    check("idle_valid", bad_v, 0);
    check("idle_pressed", bad_p, 0);

    // Key 9 (row 2, col 1) held 3 frames: first frame end at 32, accept at 48.
    held = 16'h0200;
    v_n  = 0;
    run_to(64);
    check("k9_pulses", v_n, 1);
    check("k9_latency", v_cyc, 48);
    check("k9_code", 32'(v_code), 32'h9);
    check("k9_pressed", 32'(key_pressed), 1);

    // Release for 2 frames: key_pressed falls right after the 96 frame end.
    held = 16'h0;
    v_n  = 0;
    run_to(95);
    check("rel_pressed_95", 32'(key_pressed), 1);
    run_to(96);
    check("rel_pressed_96", 32'(key_pressed), 0);
    check("rel_pulses", v_n, 0);
    check("rel_code", 32'(key_code), 32'h9);

    // One-frame bounce, then two keys in column 2 (rows 0 and 3) for two frames.
    held = 16'h0200;
    v_n  = 0;
    run_to(112);
    held = 16'h0;
    run_to(128);
    held = 16'h4004;
    run_to(160);
    check("bounce_multi_pulses", v_n, 0);
    check("bounce_multi_pressed", 32'(key_pressed), 0);

    // Key 5, then key 6 added, then key 5 released: no rollover.
    held = 16'h0020;
    run_to(192);
    check("k5_pulses", v_n, 1);
    check("k5_latency", v_cyc, 192);
    check("k5_code", 32'(v_code), 32'h5);
    v_n  = 0;
    held = 16'h0060;
    run_to(208);
    check("k56_pressed", 32'(key_pressed), 1);
    held = 16'h0040;
    run_to(240);
    check("k6_pulses", v_n, 0);
    check("k6_code", 32'(key_code), 32'h5);
    check("k6_pressed", 32'(key_pressed), 1);
    held = 16'h0;
    run_to(271);
    check("k6_rel_271", 32'(key_pressed), 1);
    run_to(272);
    check("k6_rel_272", 32'(key_pressed), 0);

    // Key 3 pressed, then reset mid-press; key stays held and is re-accepted.
    held = 16'h0008;
    v_n  = 0;
    run_to(310);
    check("k3_pulses", v_n, 1);
    check("k3_latency", v_cyc, 304);
    check("k3_code", 32'(v_code), 32'h3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_pressed", 32'(key_pressed), 0);
    check("mid_rst_cols", 32'(cols), 32'hE);
    check("mid_rst_valid", 32'(key_valid), 0);
    v_n = 0;
    run_to(40);
    check("k3_re_pulses", v_n, 1);
    check("k3_re_latency", v_cyc, 32);
    check("k3_re_code", 32'(v_code), 32'h3);
    check("k3_re_pressed", 32'(key_pressed), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
